// File: rtl/shift_pkg.sv
// shift_pkg: shift-unit op encodings, shadow-stage record and pipeline depth
package shift_pkg;
    localparam int SH_DEPTH = 2;
    localparam int SH_HART_W = 8;
    localparam int SH_RD_W = 8;
    localparam logic [2:0] OPG_SHIFT = 3'd0;
    localparam logic [2:0] OPG_ROT = 3'd1;
    localparam logic [2:0] OPG_BITCNT = 3'd2;
    localparam logic [2:0] OPG_BITMAN = 3'd3;
    localparam logic [2:0] OPG_EXT = 3'd4;
    localparam int CTL_RIGHT = 0;
    localparam int CTL_ARITH = 1;
    localparam int CTL_W32 = 6;
    localparam logic [6:0] OP_SLLI = {1'b0, OPG_SHIFT, 3'b000};
    localparam logic [6:0] OP_SRLI = {1'b0, OPG_SHIFT, 3'b001};
    localparam logic [6:0] OP_SRAI = {1'b0, OPG_SHIFT, 3'b011};
    typedef struct packed {
        logic                 v;
        logic [SH_HART_W-1:0] hart;
        logic [SH_RD_W-1:0]   rd;
    } sh_stage_t;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter; search starts at ptr, returns one-hot grant and its index
module rr_arb #(
    parameter int N = 2,
    parameter int LN = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LN-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [LN-1:0] gnt_idx
);
    logic [LN-1:0] idx;
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = LN'((int'(ptr) + i) % N);
            if (~|gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx = idx;
            end
        end
    end
endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin issue into the shared shift unit, shadow pipeline qualifying its writeback
module shift_sched
    import shift_pkg::*;
#(
    parameter int NHART = 2,
    parameter int LNHART = 1,
    parameter int LNCOMMIT = 5,
    parameter int CNTRL_SIZE = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NHART-1:0]            req_valid,
    output logic [NHART-1:0]            req_ready,
    input  logic [NHART*CNTRL_SIZE-1:0] req_control,
    input  logic [NHART*LNCOMMIT-1:0]   req_rd,
    input  logic [NHART-1:0]            req_makes_rd,
    input  logic [NHART-1:0]            req_needs_rs2,
    input  logic [NHART*32-1:0]         req_immed,
    input  logic [NHART-1:0]            hart_rv32,
    input  logic [NHART-1:0]            flush,
    input  logic                        wb_reserved,
    output logic                        sh_enable,
    output logic                        sh_makes_rd,
    output logic                        sh_needs_rs2,
    output logic                        sh_rv32,
    output logic [CNTRL_SIZE-1:0]       sh_control,
    output logic [LNCOMMIT-1:0]         sh_rd,
    output logic [31:0]                 sh_immed,
    output logic [LNHART-1:0]           sh_hart,
    input  logic [LNCOMMIT-1:0]         sh_res_rd,
    input  logic [NHART-1:0]            sh_res_makes_rd,
    output logic [NHART-1:0]            wb_valid,
    output logic [LNCOMMIT-1:0]         wb_rd,
    output logic                        idle
);
    logic [NHART-1:0] elig, gnt, exp_wb;
    logic [LNHART-1:0] gidx, rr_q, rr_d;
    logic mismatch;
    sh_stage_t st_q [SH_DEPTH];
    sh_stage_t st_d [SH_DEPTH];
    sh_stage_t s2;
    // chk marks stages whose unit-side contents are known, i.e. not flushed and not stale after reset
    logic [SH_DEPTH-1:0] chk_q, chk_d;

    function automatic logic hit(sh_stage_t s, logic [NHART-1:0] f);
        logic r;
        r = 1'b0;
        for (int h = 0; h < NHART; h++) r |= f[h] & (s.hart == SH_HART_W'(h));
        return r & s.v;
    endfunction

    assign elig = req_valid & ~flush & {NHART{~(wb_reserved | reset)}};

    rr_arb #(.N(NHART), .LN(LNHART)) u_arb (
        .req(elig),
        .ptr(rr_q),
        .gnt(gnt),
        .gnt_idx(gidx)
    );

    assign req_ready = gnt;
    assign sh_enable = |gnt & req_makes_rd[gidx];
    assign sh_makes_rd = sh_enable;
    assign sh_needs_rs2 = req_needs_rs2[gidx];
    assign sh_rv32 = hart_rv32[gidx];
    assign sh_control = req_control[gidx*CNTRL_SIZE +: CNTRL_SIZE];
    assign sh_rd = req_rd[gidx*LNCOMMIT +: LNCOMMIT];
    assign sh_immed = req_immed[gidx*32 +: 32];
    assign sh_hart = gidx;

    always_comb begin
        rr_d = (NHART == 1 || ~|gnt) ? rr_q : (gidx == LNHART'(NHART - 1)) ? '0 : gidx + 1'b1;
        st_d[0] = '{v: sh_enable, hart: SH_HART_W'(gidx), rd: SH_RD_W'(sh_rd)};
        chk_d[0] = 1'b1;
        for (int i = 1; i < SH_DEPTH; i++) begin
            st_d[i] = st_q[i-1];
            st_d[i].v = st_q[i-1].v & ~hit(st_q[i-1], flush);
            chk_d[i] = chk_q[i-1] & ~hit(st_q[i-1], flush);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= '0;
            st_q <= '{default: '0};
            chk_q <= '0;
        end else begin
            rr_q <= rr_d;
            st_q <= st_d;
            chk_q <= chk_d;
        end
    end

    assign s2 = st_q[SH_DEPTH-1];

    always_comb begin
        exp_wb = '0;
        for (int h = 0; h < NHART; h++) exp_wb[h] = s2.v & (s2.hart == SH_HART_W'(h));
        idle = ~|gnt;
        for (int i = 0; i < SH_DEPTH; i++) idle &= ~st_q[i].v;
    end

    // a result the shadow does not expect (flushed or stale after reset) is never written back
    assign mismatch = exp_wb != sh_res_makes_rd;
    assign wb_valid = (mismatch | reset) ? '0 : exp_wb & ~flush;
    assign wb_rd = sh_res_rd;

    always_ff @(posedge clk) begin
        if (!reset && chk_q[SH_DEPTH-1]) assert (!mismatch && (!s2.v || s2.rd == SH_RD_W'(sh_res_rd)));
    end
endmodule
